btn_opsel: RTL and testbench
============================

# btn_opsel

Button front-end for the 4-bit ALU board demo. It samples the five raw push-buttons and debounces each one. It converts clean presses into a registered 3-bit ALU opcode `instr` and an enable flag `en`, which feed the ALU datapath and the opcode seven-segment digit directly. Every output is a flop; there is no combinational path from `button` to any output.

## Interface
Parameters:
- `DB_CYCLES`, default 1000: consecutive stable synchronised samples required before a button level is accepted; must be ≥1.

Ports:
- `clk` input 1: the only clock; all flops are on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `button` input 5: raw buttons, active-high (1 = pressed). Bit assignment:
  - [0] C: toggle `en`
  - [1] U: `instr`+1
  - [2] D: `instr`−1
  - [3] L: `instr`=0
  - [4] R: reserved, debounced only
- `instr` output 3: current ALU opcode.
- `en` output 1: ALU enable.
- `instr_chg` output 1: one-cycle pulse in the cycle `instr` takes a new value.
- `btn_db` output 5: debounced button levels.

## Operation
- Per button, three stages:
  - Two-flop synchroniser: `button` → s1 → s2.
  - Debounce counter `cnt`, width $clog2(DB_CYCLES)+1.
  - Debounced level `db`.
- Each edge, debounce update:
  - If s2 == db: `cnt`←0.
  - Else if `cnt` == DB_CYCLES−1: `db`←s2, `cnt`←0, `press`←s2 (0→1 only).
  - Else: `cnt`←`cnt`+1.
  - `press` is 0 on every other edge.
- Effect of a glitch: any bounce shorter than DB_CYCLES samples resets `cnt` and is discarded.
- Releases are debounced the same way and generate no event.
- Opcode update, on the edge after a `press` pulse, by priority:
  - L pressed: `instr`←0.
  - Else U and D both pressed: no change.
  - Else U pressed: `instr`←`instr`+1, wrapping 7→0.
  - Else D pressed: `instr`←`instr`−1, wrapping 0→7.
- `instr_chg`←1 exactly when the new `instr` differs from the old one. L pressed at `instr`=0 gives no pulse.
- Enable: a C press toggles `en`. It is independent of, and concurrent with, opcode updates.
- Holding a button produces exactly one event, with no auto-repeat. Another event needs a debounced release followed by a new press.
- R only drives `btn_db[4]`.

## Timing
- Reset (`rst_n` low, asynchronous): all of the following are 0:
  - `instr`, `en`, `instr_chg`, `btn_db`
  - s1, s2, `cnt`, `press`
- Reset release: state holds until the first edge with `rst_n` high.
- A button already held when reset is released is treated as a new press after the normal latency.
- Press latency, with the button sampled high at edge E0 and held stable:
  - s2 = 1 at E1.
  - `db`/`press` = 1 at E(DB_CYCLES+1).
  - `instr`/`en`/`instr_chg` update at E(DB_CYCLES+2).
- `btn_db` equals `db`, so it lags the raw input by DB_CYCLES+1 edges.
- Reset asserted mid-debounce aborts the count; no event is produced.
- Throughput: at most one event per button per 2·DB_CYCLES edges (press plus release).

## Structure
- Shared package `btn_pkg` holds:
  - Index constants `BTN_C`=0, `BTN_U`=1, `BTN_D`=2, `BTN_L`=3, `BTN_R`=4.
  - `INSTR_W`=3.
  - `NUM_BTN`=5.
- Sub-module `btn_debounce`: one button's synchroniser, counter and `db`/`press` flops. It takes the `DB_CYCLES` parameter and is instantiated 5× by a generate loop.
- `btn_opsel` holds only the priority logic and the `instr`/`en`/`instr_chg` registers.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset: hold `rst_n`=0 with buttons toggling → `instr`=0, `en`=0, `instr_chg`=0, `btn_db`=0 throughout. Release → all still 0.
- U held for 20 cycles, first sampled at E0 → `instr` 0→1 at E6 with `instr_chg` high for 1 cycle. Repeat 8 clean presses → `instr` returns to 0 (wrap).
- Starting from `instr`=0, one D press → `instr`=7 and `instr_chg` pulses. U pulses of 3 cycles, or bouncing 1-0-1-0 → `instr` unchanged and `btn_db[1]` stays 0.
- C held for 50 cycles → `en` 0→1 once. Release, then press again → `en`=0. C and U pressed in the same cycle from `instr`=2, `en`=0 → `instr`=3 and `en`=1 on the same edge.
- From `instr`=5:
  - L+U in the same cycle → `instr`=0.
  - Then U+D in the same cycle → `instr` stays 0 with no `instr_chg`.
  - Then L alone → no `instr_chg`.
- Assert `rst_n` at `cnt`=2 during a U press → everything clears and no event occurs. Keep U held through reset release → `instr`=1 at the 6th edge after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and types for the ALU-board button front-end.
package btn_pkg;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned INSTR_W = 3;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 3;
  localparam int unsigned BTN_R = 4;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Buttons whose presses drive opcode/enable events; R is level-only.
  localparam btn_vec_t EVENT_MASK = btn_vec_t'((1 << BTN_C) | (1 << BTN_U) |
                                               (1 << BTN_D) | (1 << BTN_L));

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             press_nxt;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      cnt   <= cnt_nxt;
      db    <= db_nxt;
      press <= press_nxt;
    end
  end

  // Any disagreement shorter than DB_CYCLES samples is discarded
  always_comb begin
    cnt_nxt   = cnt;
    db_nxt    = db;
    press_nxt = 1'b0;
    if (s2 == db) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_MAX) begin
      db_nxt    = s2;
      cnt_nxt   = '0;
      press_nxt = s2;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/btn_opsel.sv
// Button front-end: debounces five buttons and turns clean presses into a
// registered ALU opcode, enable flag and opcode-change pulse.
module btn_opsel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] button,
  output logic [INSTR_W-1:0] instr,
  output logic               en,
  output logic               instr_chg,
  output logic [NUM_BTN-1:0] btn_db
);

  btn_vec_t db;
  btn_vec_t press;
  btn_vec_t ev;
  instr_t   instr_nxt;
  logic     en_nxt;
  logic     chg_nxt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button[i]),
      .db    (db[i]),
      .press (press[i])
    );
  end

  assign btn_db = db;
  assign ev     = press & EVENT_MASK;

  // Opcode priority: L clears, U+D cancel, then U/D step with wrap
  always_comb begin
    instr_nxt = instr;
    en_nxt    = en;
    if (ev[BTN_L]) begin
      instr_nxt = '0;
    end else if (ev[BTN_U] && ev[BTN_D]) begin
      instr_nxt = instr;
    end else if (ev[BTN_U]) begin
      instr_nxt = instr + INSTR_W'(1);
    end else if (ev[BTN_D]) begin
      instr_nxt = instr - INSTR_W'(1);
    end
    if (ev[BTN_C]) begin
      en_nxt = ~en;
    end
    chg_nxt = (instr_nxt != instr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr     <= '0;
      en        <= 1'b0;
      instr_chg <= 1'b0;
    end else begin
      instr     <= instr_nxt;
      en        <= en_nxt;
      instr_chg <= chg_nxt;
    end
  end

endmodule

// File: tb/tb_btn_opsel.sv
// Randomised and directed bench for btn_opsel against a sample-history reference model.
`timescale 1ns/1ps
module tb_btn_opsel;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] button = '0;
  logic [2:0] instr;
  logic       en;
  logic       instr_chg;
  logic [4:0] btn_db;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw sample history, stability run lengths, accepted levels
  logic [4:0] hist[$];
  int         run[5];
  logic [4:0] m_db;
  logic [4:0] m_evt;
  logic [2:0] m_instr;
  logic       m_en;
  logic       m_chg;

  btn_opsel #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .instr     (instr),
    .en        (en),
    .instr_chg (instr_chg),
    .btn_db    (btn_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    foreach (run[i]) run[i] = 0;
    m_db = '0; m_evt = '0; m_instr = '0; m_en = 1'b0; m_chg = 1'b0;
  endtask

  // One rising edge of the reference behaviour
  task automatic model_edge();
    logic [4:0] seen;
    logic [4:0] evt;
    logic [2:0] ni;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // events accepted on the previous edge act now
    ni = m_instr;
    if (m_evt[3])                 ni = 3'd0;
    else if (m_evt[1] && m_evt[2]) ni = m_instr;
    else if (m_evt[1])            ni = 3'((int'(m_instr) + 1) % 8);
    else if (m_evt[2])            ni = 3'((int'(m_instr) + 7) % 8);
    m_chg   = (ni != m_instr);
    m_instr = ni;
    if (m_evt[0]) m_en = ~m_en;
    // the level the debouncer judges this edge is the raw sample two edges back
    hist.push_back(button);
    seen = (hist.size() >= 3) ? hist[hist.size()-3] : 5'd0;
    while (hist.size() > 3) void'(hist.pop_front());
    evt = '0;
    for (int b = 0; b < 5; b++) begin
      if (seen[b] != m_db[b]) begin
        run[b]++;
        if (run[b] == int'(DB)) begin
          m_db[b] = seen[b];
          run[b]  = 0;
          evt[b]  = seen[b] && (b != 4);
        end
      end else begin
        run[b] = 0;
      end
    end
    m_evt = evt;
  endtask

  task automatic cycle(input logic [4:0] b, input logic r);
    @(negedge clk);
    button = b;
    rst_n  = r;
    @(posedge clk);
    model_edge();
    #1;
    check("instr",     8'(instr),     8'(m_instr));
    check("en",        8'(en),        8'(m_en));
    check("instr_chg", 8'(instr_chg), 8'(m_chg));
    check("btn_db",    8'(btn_db),    8'(m_db));
  endtask

  task automatic hold(input logic [4:0] b, input int n);
    repeat (n) cycle(b, 1'b1);
  endtask

  task automatic press(input logic [4:0] b);
    hold(b, 10);
    hold(5'd0, 10);
  endtask

  logic [4:0] lvl;
  int         left[5];

  initial begin
    model_reset();
    #1;
    check("rst_instr", 8'(instr), 8'd0);
    check("rst_btn_db", 8'(btn_db), 8'd0);
    // reset held while buttons toggle
    repeat (8) cycle(5'($urandom), 1'b0);
    hold(5'd0, 3);

    // U held: single event, then wrap through eight presses
    hold(5'b00010, 20);
    hold(5'd0, 10);
    check("u_first", 8'(instr), 8'd1);
    repeat (7) press(5'b00010);
    check("u_wrap", 8'(instr), 8'd0);

    press(5'b00100);
    check("d_wrap", 8'(instr), 8'd7);

    // short pulses and bounce are discarded
    hold(5'b00010, 3);
    hold(5'd0, 6);
    repeat (3) begin
      cycle(5'b00010, 1'b1);
      cycle(5'd0, 1'b1);
    end
    hold(5'd0, 8);
    check("glitch", 8'(instr), 8'd7);

    // enable toggling and concurrent C+U
    hold(5'b00001, 50);
    hold(5'd0, 10);
    check("en_on", 8'(en), 8'd1);
    press(5'b00001);
    check("en_off", 8'(en), 8'd0);
    press(5'b01000);
    press(5'b00010);
    press(5'b00010);
    press(5'b00011);
    check("cu_instr", 8'(instr), 8'd3);
    check("cu_en", 8'(en), 8'd1);

    // priority cases from instr=5
    press(5'b00010);
    press(5'b00010);
    press(5'b01010);
    check("lu", 8'(instr), 8'd0);
    press(5'b00110);
    press(5'b01000);
    press(5'b10000);
    check("lud_end", 8'(instr), 8'd0);

    // reset mid-debounce, U held through release
    hold(5'b00010, 4);
    repeat (3) cycle(5'b00010, 1'b0);
    hold(5'b00010, 20);
    hold(5'd0, 10);
    check("rst_abort", 8'(instr), 8'd1);

    // random per-button levels with random hold lengths and occasional resets
    lvl = '0;
    foreach (left[i]) left[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = 1'($urandom);
          left[b] = int'($urandom_range(1, 12));
        end
        left[b]--;
      end
      if ($urandom_range(0, 499) == 0) repeat (3) cycle(lvl, 1'b0);
      else cycle(lvl, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
